// File: rtl/user_rd_reg_pkg.sv
// Shared definitions for the JTAG user read register: FSM encoding and
// the data-register clock-enable gating used by the user_* registers.
package user_rd_reg_pkg;

    // Read-transaction state. The encoding stays fixed so that existing
    // debug tooling can decode DBG_STATE directly.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPT     = 2'd1,
        ST_SHIFTING = 2'd2
    } rd_state_e;

    // The register responds only when user mode is selected, the data
    // register clock is enabled, and it is addressed either stand-alone
    // (FSEL) or as part of a daisy chain.
    function automatic logic usr_act(
        input logic sel,
        input logic fsel,
        input logic dsy_chain,
        input logic drck_en
    );
        return sel & (fsel | dsy_chain) & drck_en;
    endfunction

endpackage

// File: rtl/user_rd_reg_sat_bit_cnt.sv
// Shift-progress counter: clears on capture, counts shifts, saturates at
// WIDTH, and keeps a sticky over-shift flag until the next clear.
module user_rd_reg_sat_bit_cnt #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          ovf_stb_o,
    output logic          ovr_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovr_q, ovr_d;
    logic          full;
    logic          ovf_stb;

    // Next count and over-shift flag; clear has priority over increment.
    always_comb begin
        full    = (cnt_q == CNT_MAX);
        ovf_stb = inc_i & full & ~clr_i;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        if (clr_i) begin
            cnt_d = '0;
            ovr_d = 1'b0;
        end else begin
            if (inc_i && !full) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (ovf_stb) begin
                ovr_d = 1'b1;
            end
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign full_o    = full;
    assign ovf_stb_o = ovf_stb;
    assign ovr_o     = ovr_q;

endmodule

// File: rtl/user_rd_reg.sv
// JTAG user read register: captures a fabric status word in Capture-DR
// and shifts it out LSB-first on TDO (stand-alone) or DSY_OUT (daisy
// chain), reporting read progress and anomalies back to the fabric.
//
// Handshake: CAP_ACK is a one-cycle pulse the cycle after PI was sampled;
// the fabric may change PI from then on. RD_DONE / RD_SHORT are one-cycle
// pulses the cycle after an UPDATE that closes an open read.
module user_rd_reg
    import user_rd_reg_pkg::*;
#(
    parameter int               width     = 16,
    parameter logic [width-1:0] def_value = '0
) (
    input  logic                       TCK,
    input  logic                       RST,
    input  logic                       DRCK_EN,
    input  logic                       FSEL,
    input  logic                       SEL,
    input  logic                       TDI,
    input  logic                       DSY_IN,
    input  logic                       CAPTURE,
    input  logic                       SHIFT,
    input  logic                       UPDATE,
    input  logic                       DSY_CHAIN,
    input  logic [width-1:0]           PI,
    input  logic                       PI_VLD,
    output logic                       TDO,
    output logic                       DSY_OUT,
    output logic                       BUSY,
    output logic                       CAP_ACK,
    output logic                       RD_DONE,
    output logic                       RD_SHORT,
    output logic                       OVR,
    output logic                       STALE,
    output logic [$clog2(width+1)-1:0] BIT_CNT,
    output logic [1:0]                 DBG_STATE
);

    localparam int CW = $clog2(width + 1);

    logic             act;
    logic             ce_cap;
    logic             ce_sh;
    logic             upd;
    logic             din;

    logic [width-1:0] d_q, d_d;
    logic             stale_q, stale_d;
    logic             cap_ack_q, cap_ack_d;
    logic             rd_done_q, rd_done_d;
    logic             rd_short_q, rd_short_d;

    rd_state_e        state_q, state_d;
    logic             busy;

    logic [CW-1:0]    cnt;
    logic             cnt_full;
    logic             cnt_ovf_stb;
    logic             cnt_ovr;

    // Clock-enable decode; a capture in the same cycle suppresses the shift.
    always_comb begin
        act    = usr_act(SEL, FSEL, DSY_CHAIN, DRCK_EN);
        ce_cap = CAPTURE & act;
        ce_sh  = SHIFT & act & ~CAPTURE;
        upd    = UPDATE & SEL;
        din    = DSY_CHAIN ? DSY_IN : TDI;
    end

    // Shift register next value: parallel load on capture, else shift right.
    always_comb begin
        d_d     = d_q;
        stale_d = stale_q;
        if (ce_cap) begin
            d_d     = PI;
            stale_d = ~PI_VLD;
        end else if (ce_sh) begin
            d_d = {din, d_q[width-1:1]};
        end
    end

    // Shift register and stale flag.
    always_ff @(posedge TCK) begin
        if (RST) begin
            d_q     <= def_value;
            stale_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            stale_q <= stale_d;
        end
    end

    // FSM state register.
    always_ff @(posedge TCK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: capture restarts a read from any state.
    always_comb begin
        state_d = state_q;
        if (ce_cap) begin
            state_d = ST_CAPT;
        end else begin
            case (state_q)
                ST_CAPT: begin
                    if (upd) begin
                        state_d = ST_IDLE;
                    end else if (ce_sh) begin
                        state_d = ST_SHIFTING;
                    end
                end
                ST_SHIFTING: begin
                    if (upd) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: a read is open in CAPT or SHIFTING; pulse requests.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        cap_ack_d  = ce_cap;
        rd_done_d  = upd & busy & ~ce_cap & cnt_full;
        rd_short_d = upd & busy & ~ce_cap & ~cnt_full;
    end

    // One-cycle status pulses towards the fabric.
    always_ff @(posedge TCK) begin
        if (RST) begin
            cap_ack_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_short_q <= 1'b0;
        end else begin
            cap_ack_q  <= cap_ack_d;
            rd_done_q  <= rd_done_d;
            rd_short_q <= rd_short_d;
        end
    end

    // Only shifts inside an open read count; idle shifts just pass data.
    user_rd_reg_sat_bit_cnt #(
        .WIDTH (width),
        .CW    (CW)
    ) u_cnt (
        .clk_i     (TCK),
        .rst_i     (RST),
        .clr_i     (ce_cap),
        .inc_i     (ce_sh & busy),
        .cnt_o     (cnt),
        .full_o    (cnt_full),
        .ovf_stb_o (cnt_ovf_stb),
        .ovr_o     (cnt_ovr)
    );

    logic unused_ovf_stb;
    assign unused_ovf_stb = cnt_ovf_stb;

    assign TDO       = FSEL & d_q[0];
    assign DSY_OUT   = DSY_CHAIN & d_q[0];
    assign BUSY      = busy;
    assign CAP_ACK   = cap_ack_q;
    assign RD_DONE   = rd_done_q;
    assign RD_SHORT  = rd_short_q;
    assign OVR       = cnt_ovr;
    assign STALE     = stale_q;
    assign BIT_CNT   = cnt;
    assign DBG_STATE = state_q;

endmodule
